// File: rtl/pc_pkg.sv
// Shared types and default vectors for the rv32 program-counter sequencer.
package pc_pkg;

   typedef enum logic {BOOT, FETCH} state_e;

   // Listed in resolution order, highest priority first.
   typedef enum logic [2:0] {
      EV_NONE,
      EV_TRAP,
      EV_MRET,
      EV_MISALIGN,
      EV_BRANCH
   } ev_e;

   localparam int          DEF_XLEN         = 32;
   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;
   localparam int          DEF_INSTR_BYTES  = 4;
   localparam int          DEF_ALIGN_BITS   = 2;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-side handshake between the PC sequencer and instruction memory.
interface pc_sequencer_if #(
   parameter int XLEN = 32
);
   logic            fetch_valid;
   logic            fetch_ready;
   logic [XLEN-1:0] pc_out;
   logic [XLEN-1:0] pc_add_4;

   modport master (output fetch_valid, pc_out, pc_add_4, input fetch_ready);
   modport slave  (input fetch_valid, pc_out, pc_add_4, output fetch_ready);
endinterface

// File: rtl/pc_target_sel.sv
// Combinational redirect resolution: picks the winning event this cycle,
// computes its target and flags misaligned branch/jump targets.
module pc_target_sel
   import pc_pkg::*;
#(
   parameter int              XLEN        = DEF_XLEN,
   parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DEF_TRAP_VECTOR),
   parameter int              ALIGN_BITS  = DEF_ALIGN_BITS
) (
   input  logic            active,
   input  logic            trap_req,
   input  logic            mret_req,
   input  logic            branch_decision,
   input  logic            pc_immediate_jump,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] epc,
   input  logic [XLEN-1:0] generated_immediate,
   input  logic [XLEN-1:0] pc_write_value,
   output ev_e             ev_kind,
   output logic            ev_valid,
   output logic            ev_trap,
   output logic [XLEN-1:0] ev_target
);
   logic [XLEN-1:0] br_target;
   logic            br_misaligned;

   always_comb begin
      br_target     = pc_immediate_jump ? (pc_write_value & ~XLEN'(1))
                                        : pc + generated_immediate;
      br_misaligned = |br_target[ALIGN_BITS-1:0];
      ev_kind       = EV_NONE;
      ev_target     = br_target;
      if (active) begin
         if (trap_req) begin
            ev_kind   = EV_TRAP;
            ev_target = TRAP_VECTOR;
         end else if (mret_req) begin
            ev_kind   = EV_MRET;
            ev_target = epc;
         end else if (branch_decision && br_misaligned) begin
            ev_kind   = EV_MISALIGN;
            ev_target = TRAP_VECTOR;
         end else if (branch_decision) begin
            ev_kind   = EV_BRANCH;
         end
      end
   end

   assign ev_valid = (ev_kind != EV_NONE);
   // Trap-class events save the EPC and may overwrite any pending redirect.
   assign ev_trap  = (ev_kind == EV_TRAP) || (ev_kind == EV_MISALIGN);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the fetch PC, handshakes it to instruction
// memory, and applies redirects immediately on accept or via a pending slot.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int              XLEN         = DEF_XLEN,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
   parameter int              INSTR_BYTES  = DEF_INSTR_BYTES,
   parameter int              ALIGN_BITS   = DEF_ALIGN_BITS
) (
   input  logic            clock,
   input  logic            reset,
   pc_sequencer_if.master  fetch,
   input  logic            in_en,
   input  logic            branch_decision,
   input  logic            pc_immediate_jump,
   input  logic [XLEN-1:0] generated_immediate,
   input  logic [XLEN-1:0] pc_write_value,
   input  logic            trap_req,
   input  logic            mret_req,
   output logic [XLEN-1:0] epc_out,
   output logic            misaligned_fault
);
   state_e          state;
   logic [XLEN-1:0] pc_q;
   logic            fv_q;
   logic            pend_valid;
   logic            pend_trap;
   logic [XLEN-1:0] pend_target;

   ev_e             ev_kind;
   logic            ev_valid;
   logic            ev_trap;
   logic [XLEN-1:0] ev_target;

   logic            accept;
   logic            ev_wins;
   logic [XLEN-1:0] sel_target;
   logic            sel_trap;
   logic [XLEN-1:0] pc_inc;

   pc_target_sel #(
      .XLEN       (XLEN),
      .TRAP_VECTOR(TRAP_VECTOR),
      .ALIGN_BITS (ALIGN_BITS)
   ) u_sel (
      .active             (state == FETCH),
      .trap_req           (trap_req),
      .mret_req           (mret_req),
      .branch_decision    (branch_decision),
      .pc_immediate_jump  (pc_immediate_jump),
      .pc                 (pc_q),
      .epc                (epc_out),
      .generated_immediate(generated_immediate),
      .pc_write_value     (pc_write_value),
      .ev_kind            (ev_kind),
      .ev_valid           (ev_valid),
      .ev_trap            (ev_trap),
      .ev_target          (ev_target)
   );

   assign pc_inc            = pc_q + XLEN'(INSTR_BYTES);
   assign fetch.pc_out      = pc_q;
   assign fetch.pc_add_4    = pc_inc;
   assign fetch.fetch_valid = fv_q;

   assign accept  = fv_q & fetch.fetch_ready & in_en;
   // A non-trap event never displaces a pending trap; it is simply dropped.
   assign ev_wins    = ev_valid & (ev_trap | ~(pend_valid & pend_trap));
   assign sel_target = ev_wins ? ev_target : pend_target;
   assign sel_trap   = ev_wins ? ev_trap   : pend_trap;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state            <= BOOT;
         pc_q             <= RESET_VECTOR;
         fv_q             <= 1'b0;
         epc_out          <= '0;
         misaligned_fault <= 1'b0;
         pend_valid       <= 1'b0;
         pend_trap        <= 1'b0;
         pend_target      <= '0;
      end else begin
         misaligned_fault <= 1'b0;
         case (state)
            BOOT: begin
               state <= FETCH;
               fv_q  <= 1'b1;
            end
            FETCH: begin
               if (ev_trap) epc_out <= pc_q;
               misaligned_fault <= (ev_kind == EV_MISALIGN);
               if (accept) begin
                  pc_q       <= (ev_valid || pend_valid) ? sel_target : pc_inc;
                  pend_valid <= 1'b0;
                  pend_trap  <= 1'b0;
               end else if (ev_valid) begin
                  pend_valid  <= 1'b1;
                  pend_trap   <= sel_trap;
                  pend_target <= sel_target;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: stimulus queues expected fetch
// addresses, a negedge monitor pops and compares them on every accepted fetch.
module tb_pc_sequencer;
   logic        clock = 1'b0;
   logic        reset;
   logic        in_en;
   logic        branch_decision;
   logic        pc_immediate_jump;
   logic [31:0] generated_immediate;
   logic [31:0] pc_write_value;
   logic        trap_req;
   logic        mret_req;
   logic [31:0] epc_out;
   logic        misaligned_fault;

   int          n_checks = 0;
   int          n_err    = 0;
   logic [31:0] exp_q[$];
   logic        prev_stall = 1'b0;
   logic [31:0] prev_pc    = '0;

   pc_sequencer_if #(.XLEN(32)) fif ();

   pc_sequencer dut (
      .clock              (clock),
      .reset              (reset),
      .fetch              (fif),
      .in_en              (in_en),
      .branch_decision    (branch_decision),
      .pc_immediate_jump  (pc_immediate_jump),
      .generated_immediate(generated_immediate),
      .pc_write_value     (pc_write_value),
      .trap_req           (trap_req),
      .mret_req           (mret_req),
      .epc_out            (epc_out),
      .misaligned_fault   (misaligned_fault)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Expect pc_out to be accepted in the cycle now being set up.
   task automatic fetch_exp(input logic [31:0] pc);
      exp_q.push_back(pc);
      step();
   endtask

   task automatic clr();
      branch_decision     = 1'b0;
      pc_immediate_jump   = 1'b0;
      generated_immediate = '0;
      pc_write_value      = '0;
      trap_req            = 1'b0;
      mret_req            = 1'b0;
   endtask

   always @(negedge clock) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && fif.fetch_valid) begin
            n_checks++;
            if (fif.pc_out !== prev_pc) begin
               n_err++;
               $display("FAIL stall_hold: got %h expected %h", fif.pc_out, prev_pc);
            end
         end
         if (fif.fetch_valid && fif.fetch_ready && in_en) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL fetch_unexpected: got %h expected none", fif.pc_out);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               if (fif.pc_out !== e) begin
                  n_err++;
                  $display("FAIL fetch_pc: got %h expected %h", fif.pc_out, e);
               end
            end
            prev_stall = 1'b0;
         end else begin
            prev_stall = fif.fetch_valid;
            prev_pc    = fif.pc_out;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      in_en = 1'b1;
      fif.fetch_ready = 1'b1;
      clr();
      #2;
      chk("reset_pc", fif.pc_out, 32'h0);
      chk("reset_valid", {31'b0, fif.fetch_valid}, 32'h0);
      chk("reset_epc", epc_out, 32'h0);
      chk("reset_fault", {31'b0, misaligned_fault}, 32'h0);
      step();
      reset = 1'b0;
      chk("boot_valid", {31'b0, fif.fetch_valid}, 32'h0);
      step();
      chk("fetch_valid_up", {31'b0, fif.fetch_valid}, 32'h1);

      // sequential 0,4 then stall at 8
      fetch_exp(32'h0);
      fetch_exp(32'h4);
      fif.fetch_ready = 1'b0;
      repeat (3) step();
      chk("stall_pc", fif.pc_out, 32'h8);
      chk("stall_valid", {31'b0, fif.fetch_valid}, 32'h1);
      fif.fetch_ready = 1'b1;
      fetch_exp(32'h8);
      chk("after_stall_pc", fif.pc_out, 32'hC);
      fetch_exp(32'hC);
      fetch_exp(32'h10);
      fetch_exp(32'h14);
      fetch_exp(32'h18);
      fetch_exp(32'h1C);

      // relative branch backwards, then absolute jump with bit 0 cleared
      branch_decision = 1'b1; generated_immediate = 32'hFFFF_FFF0;
      fetch_exp(32'h20);
      clr(); branch_decision = 1'b1; pc_immediate_jump = 1'b1; pc_write_value = 32'h41;
      fetch_exp(32'h10);
      clr(); branch_decision = 1'b1; generated_immediate = 32'hFFFF_FFF0;
      fetch_exp(32'h40);

      // misaligned target at 0x30 -> trap vector
      clr(); branch_decision = 1'b1; generated_immediate = 32'h6;
      fetch_exp(32'h30);
      clr();
      chk("misalign_epc", epc_out, 32'h30);
      chk("misalign_pulse", {31'b0, misaligned_fault}, 32'h1);
      fetch_exp(32'h100);
      chk("misalign_pulse_end", {31'b0, misaligned_fault}, 32'h0);

      // trap during stall keeps priority over a later branch
      branch_decision = 1'b1; pc_immediate_jump = 1'b1; pc_write_value = 32'h44;
      fetch_exp(32'h104);
      clr(); fif.fetch_ready = 1'b0; trap_req = 1'b1;
      step();
      chk("trap_epc_stalled", epc_out, 32'h44);
      clr(); branch_decision = 1'b1; generated_immediate = 32'h8;
      step();
      clr(); fif.fetch_ready = 1'b1;
      fetch_exp(32'h44);
      chk("trap_kept_pc", fif.pc_out, 32'h100);
      fetch_exp(32'h100);
      mret_req = 1'b1;
      fetch_exp(32'h104);
      clr();
      chk("mret_pc", fif.pc_out, 32'h44);
      fetch_exp(32'h44);

      // simultaneous trap and mret: trap wins
      trap_req = 1'b1; mret_req = 1'b1;
      fetch_exp(32'h48);
      clr();
      chk("trap_mret_epc", epc_out, 32'h48);

      // in_en low: branch latched into pending, applied on enable
      in_en = 1'b0; branch_decision = 1'b1; generated_immediate = 32'h20;
      step();
      clr();
      step();
      chk("disabled_pc", fif.pc_out, 32'h100);
      chk("disabled_valid", {31'b0, fif.fetch_valid}, 32'h1);
      in_en = 1'b1;
      fetch_exp(32'h100);

      // wrap-around at top of address space
      branch_decision = 1'b1; pc_immediate_jump = 1'b1; pc_write_value = 32'hFFFF_FFFC;
      fetch_exp(32'h120);
      clr();
      chk("wrap_add4", fif.pc_add_4, 32'h0);
      fetch_exp(32'hFFFF_FFFC);
      fetch_exp(32'h0);

      // async reset mid-stall
      fif.fetch_ready = 1'b0;
      step();
      #2 reset = 1'b1;
      #1;
      chk("async_rst_pc", fif.pc_out, 32'h0);
      chk("async_rst_valid", {31'b0, fif.fetch_valid}, 32'h0);
      chk("async_rst_epc", epc_out, 32'h0);
      step();
      reset = 1'b0;
      step();
      chk("scoreboard_empty", exp_q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer for the rv32 core; successor to the basic PC register.
- Holds the fetch address and presents it to instruction memory over a valid/ready handshake.
- Selects the next PC from sequential, branch, jump, trap and return redirects.
- Detects misaligned redirect targets and routes them to the trap vector, saving the faulting PC in an internal EPC register.

Parameters:
XLEN, 32, address/data width
RESET_VECTOR, 32'h0000_0000, pc_out value at reset
TRAP_VECTOR, 32'h0000_0100, redirect target for trap_req and misaligned targets
INSTR_BYTES, 4, sequential increment; legal values 2 or 4
ALIGN_BITS, 2, low target bits that must be zero (log2 of INSTR_BYTES)

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-high reset
in_en  in  1  global enable; low freezes PC advance
fetch_ready  in  1  instruction memory accepts pc_out this cycle
branch_decision  in  1  take redirect (branch or jump) this cycle
pc_immediate_jump  in  1  with branch_decision: absolute target pc_write_value, else pc_out+generated_immediate
generated_immediate  in  XLEN  PC-relative offset
pc_write_value  in  XLEN  absolute jump target (bit 0 cleared before use)
trap_req  in  1  exception/interrupt redirect pulse
mret_req  in  1  return-from-trap pulse
pc_out  out  XLEN  current fetch address
pc_add_4  out  XLEN  pc_out + INSTR_BYTES (combinational)
fetch_valid  out  1  pc_out is a valid fetch request
epc_out  out  XLEN  saved exception PC
misaligned_fault  out  1  one-cycle pulse: misaligned redirect target replaced by TRAP_VECTOR

Behaviour:
- Reset (async, high): pc_out=RESET_VECTOR, epc_out=0, fetch_valid=0, misaligned_fault=0, pending cleared, state=BOOT. Reset mid-handshake aborts it with no further side effects.
- FSM states:
  - BOOT: fetch_valid=0 for exactly one cycle after reset release, then FETCH.
  - FETCH: fetch_valid=1.
  - No other states.
- accept = fetch_valid & fetch_ready & in_en.
- Stability rule: while fetch_valid=1 and accept=0, pc_out must not change.
- Event resolution, every cycle in FETCH, highest priority first:
  - trap_req: target=TRAP_VECTOR; epc<=pc_out.
  - mret_req: target=epc_out.
  - branch_decision with target[ALIGN_BITS-1:0]!=0: target=TRAP_VECTOR; epc<=pc_out; misaligned_fault=1 next cycle.
  - branch_decision: target = pc_immediate_jump ? {pc_write_value[XLEN-1:1],1'b0} : pc_out+generated_immediate.
- Arithmetic is modulo 2^XLEN: wrap-around with no flag; a negative immediate is two's-complement.
- epc is written in the event cycle, even if accept=0.
- Next-PC on accept:
  - Event this cycle: pc_out<=target.
  - Else pending_valid: pc_out<=pending_target; pending cleared.
  - Else pc_out<=pc_add_4.
- Event without accept: latch pending_target/pending_trap, pending_valid=1. Redirect latency is one cycle after the accepting cycle.
- Pending overwrite rules:
  - A new trap/misaligned event always overwrites pending.
  - A branch/mret event does not overwrite a pending trap.
  - Otherwise the newer event replaces the older.
- Event and pending both present on accept: event wins, subject to the overwrite rules; the result is applied and pending is cleared.
- in_en=0: no advance; events still latch into pending; fetch_valid stays 1.
- Simultaneous trap_req and mret_req: trap wins; mret dropped.

Decomposition:
- Package pc_pkg: state enum (BOOT, FETCH), event-priority enum, default vector constants.
- One natural sub-module: pc_target_sel. It is combinational: priority resolution, target compute and misalignment check.
- pc_sequencer keeps the FSM, the pc/epc/pending registers and the handshake.

Test Plan:
- Reset release, fetch_ready=1, in_en=1 -> one cycle fetch_valid=0, then pc_out 0,4,8,12 on consecutive cycles.
- fetch_ready=0 for 3 cycles at pc=8 -> pc_out held at 8, fetch_valid=1; ready high -> pc_out=12 next cycle.
- At pc=0x20: branch_decision=1, imm=0xFFFF_FFF0 -> pc_out=0x10; with pc_immediate_jump=1, pc_write_value=0x41 -> pc_out=0x40.
- branch to pc_out+6 at pc=0x30 -> pc_out=0x100, epc_out=0x30, misaligned_fault pulses once.
- trap_req at pc=0x44 with fetch_ready=0, branch in the next stalled cycle, then ready -> pc_out=0x100 (trap kept), epc_out=0x44; later mret_req -> pc_out=0x44.
- pc=0xFFFF_FFFC, sequential -> pc_out=0x0; async reset asserted mid-stall -> pc_out=0, fetch_valid=0 immediately.
